timer_arbiter: RTL and testbench

//  Shares one flex_counter instance between NUM_REQ requesters that each need a timed interval.
//  - Arbitrates pending requests round-robin.
//  - Loads the winner's length into the counter, clears it, then enables counting.
//  - Pulses done to the winner on rollover.
//  - Sits between requesting control FSMs and the shared counter.

---
 rtl/timer_arbiter.sv | 177 +++++++++++++++++
 tb/tb_timer_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//
// Shares one external flex_counter between NUM_REQ requesters. Pending requests
// are served round-robin. For the winner, the counter is cleared and loaded
// with that requester's interval length, then enabled until it rolls over.
// The winner then gets a one-cycle done pulse.
//
// Optional feature (macro TIMER_ARB_ABORT_EN):
//   If the owner drops its req while its service is in LOAD or COUNT, the
//   service is aborted. On the next cycle the state is IDLE, grant is 0,
//   cnt_clear is 1 for that cycle, and no done pulse is issued.
//   When the macro is undefined, a dropped req is ignored and the service
//   completes normally.
//
// Handshake: req[i] is a level request that the requester holds until done[i]
// pulses. grant[i] is high while requester i owns the counter (LOAD..COUNT).
// done[i] is a one-cycle pulse in the cycle after ownership ends; grant is
// already low in that cycle. A requester whose req is still high after done
// competes again from the next IDLE cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req                 [NUM_REQ] level requests
//   req_len             [NUM_REQ*NUM_CNT_BITS] interval length per lane
//   grant               [NUM_REQ] one-hot owner, 0 when idle
//   done                [NUM_REQ] one-cycle completion pulse
//   busy                state != IDLE
//   cnt_clear           counter clear (also forced high while rst=1)
//   cnt_enable          counter count_enable
//   cnt_rollover_val    counter rollover_val
//   cnt_rollover_flag   counter rollover_flag
//   dbg_state_o         current FSM state (IDLE=0, LOAD=1, COUNT=2, DONE=3)
// -----------------------------------------------------------------------------
module timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] req_len,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            cnt_clear,
  output logic                            cnt_enable,
  output logic [NUM_CNT_BITS-1:0]         cnt_rollover_val,
  input  logic                            cnt_rollover_flag,
  output logic [1:0]                      dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CNT_BITS-1:0] len_q, len_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
`ifdef TIMER_ARB_ABORT_EN
  logic                    abort_q, abort_d;
`endif

  logic                    arb_found;
  logic [IDX_W-1:0]        arb_idx;
  logic [NUM_CNT_BITS-1:0] arb_len;
  logic [IDX_W-1:0]        ptr_next;
  logic [NUM_REQ-1:0]      owner_oh;
  int                      arb_c;

  // Round-robin pick: first set req bit at or after ptr_q, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_c     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_c = int'(ptr_q) + k;
      if (arb_c >= NUM_REQ) arb_c = arb_c - NUM_REQ;
      if (!arb_found && req[IDX_W'(arb_c)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(arb_c);
      end
    end
  end

  // Length lane of the winner, selected with constant part-selects.
  always_comb begin
    arb_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == arb_idx) arb_len = req_len[i*NUM_CNT_BITS +: NUM_CNT_BITS];
    end
  end

  // Pointer moves one past the owner, so the owner has lowest priority next time.
  assign ptr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    owner_oh        = '0;
    owner_oh[idx_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
`ifdef TIMER_ARB_ABORT_EN
    abort_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_LOAD;
          idx_d   = arb_idx;
          len_d   = arb_len;
        end
      end
      S_LOAD:  state_d = (len_q == '0) ? S_DONE : S_COUNT;
      S_COUNT: if (cnt_rollover_flag) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = ptr_next;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef TIMER_ARB_ABORT_EN
    // The owner withdrawing its request wins over a coincident rollover.
    if ((state_q == S_LOAD || state_q == S_COUNT) && !req[idx_q]) begin
      state_d = S_IDLE;
      ptr_d   = ptr_next;
      abort_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
`ifdef TIMER_ARB_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
`ifdef TIMER_ARB_ABORT_EN
      abort_q <= abort_d;
`endif
    end
  end

  // Moore outputs
  assign busy             = (state_q != S_IDLE);
  assign grant            = (state_q == S_LOAD || state_q == S_COUNT) ? owner_oh : '0;
  assign done             = (state_q == S_DONE) ? owner_oh : '0;
  assign cnt_enable       = (state_q == S_COUNT) && !cnt_rollover_flag;
  assign cnt_rollover_val = (state_q == S_LOAD || state_q == S_COUNT) ? len_q : '0;
  assign dbg_state_o      = state_q;
  // rst is included combinationally so the counter is flushed during reset.
  // An aborted service also flushes the counter on its IDLE cycle.
`ifdef TIMER_ARB_ABORT_EN
  assign cnt_clear = rst || (state_q == S_LOAD) || abort_q;
`else
  assign cnt_clear = rst || (state_q == S_LOAD);
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [15:0] req_len = 16'h0;
  logic [3:0]  grant, done;
  logic        busy, cnt_clear, cnt_enable;
  logic [3:0]  cnt_rollover_val;
  logic        cnt_rollover_flag;
  logic [1:0]  dbg_state_o;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  timer_arbiter #(.NUM_REQ(4), .NUM_CNT_BITS(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .req_len           (req_len),
    .grant             (grant),
    .done              (done),
    .busy              (busy),
    .cnt_clear         (cnt_clear),
    .cnt_enable        (cnt_enable),
    .cnt_rollover_val  (cnt_rollover_val),
    .cnt_rollover_flag (cnt_rollover_flag),
    .dbg_state_o       (dbg_state_o)
  );

  // Reference flex_counter: counts 1..rollover_val, flag registered with the count.
  logic [3:0] cnt_q = 4'd0;
  logic       flag_q = 1'b0;
  logic [3:0] cnt_nxt;
  assign cnt_nxt           = (cnt_q == cnt_rollover_val) ? 4'd1 : cnt_q + 4'd1;
  assign cnt_rollover_flag = flag_q;

  always @(posedge clk) begin
    if (cnt_clear) begin
      cnt_q  <= 4'd0;
      flag_q <= 1'b0;
    end else if (cnt_enable) begin
      cnt_q  <= cnt_nxt;
      flag_q <= (cnt_nxt == cnt_rollover_val);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      assert (((|done) && (|grant)) === 1'b0 && $onehot0(done) && $onehot0(grant)) else begin
        failures++;
        $error("FAIL invariant observed grant=%b done=%b expected onehot0 and disjoint", grant, done);
      end
    end
  end

  // Count negedges until a grant appears (bounded).
  task automatic wait_grant(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (grant !== 4'b0) begin
        cycles = k;
        break;
      end
    end
  endtask

  // Called on the negedge where the grant is first visible (LOAD cycle).
  // Returns on the negedge where done is visible.
  task automatic service(input int lane, input int len, input int exp_lat, input int drop_at);
    logic [3:0] oh;
    int en;
    int lat;
    oh  = 4'b0001 << lane;
    en  = 0;
    lat = -1;
    chk("load_grant", grant, oh);
    chk("load_clear", cnt_clear, 1);
    chk("load_rollover_val", cnt_rollover_val, len);
    chk("load_busy", busy, 1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done !== 4'b0) begin
        lat = k;
        break;
      end
      if (cnt_enable === 1'b1) en++;
      chk("grant_hold", grant, oh);
      chk("rollover_val_hold", cnt_rollover_val, len);
      if (k == drop_at) req[lane] = 1'b0;
    end
    chk("done_onehot", done, oh);
    chk("done_grant_low", grant, 0);
    chk("done_latency", lat, exp_lat);
    chk("enable_cycles", en, len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", cnt_enable, 0);
    chk("rst_clear", cnt_clear, 1);
    chk("rst_rollover_val", cnt_rollover_val, 0);
    chk("rst_state", dbg_state_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_clear", cnt_clear, 0);
    chk("post_rst_busy", busy, 0);

    // 2. single request, len 10: done 12 cycles after grant
    req_len = 16'h000A;
    req     = 4'b0001;
    wait_grant(n);
    chk("t2_grant_latency", n, 1);
    service(0, 10, 12, -1);
    req = 4'b0;
    @(negedge clk);
    chk("t2_done_single", done, 0);
    chk("t2_idle_busy", busy, 0);

    // 3. all four requesting, len 3: order 0,1,2,3,0 with one idle cycle between
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    req_len = 16'h3333;
    req     = 4'b1111;
    wait_grant(n);
    chk("t3_first_grant_latency", n, 1);
    for (int i = 0; i < 5; i++) begin
      service(i % 4, 3, 5, -1);
      if (i < 4) begin
        wait_grant(n);
        chk("t3_gap", n, 2);
      end
    end
    req = 4'b0;
    @(negedge clk);
    chk("t3_done_single", done, 0);

    // 4. zero length: LOAD goes straight to DONE, no counting
    req_len = 16'h0000;
    req     = 4'b0010;
    wait_grant(n);
    chk("t4_grant_latency", n, 1);
    service(1, 0, 1, -1);
    req = 4'b0;
    @(negedge clk);
    chk("t4_done_single", done, 0);

    // 5. owner drops req after 4 counting cycles
    req_len = 16'h0A00;
    req     = 4'b0100;
    wait_grant(n);
    chk("t5_grant_latency", n, 1);
`ifdef TIMER_ARB_ABORT_EN
    chk("t5_grant", grant, 4'b0100);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t5_enable", cnt_enable, 1);
      if (k == 4) req[2] = 1'b0;
    end
    @(negedge clk);
    chk("t5_abort_grant", grant, 0);
    chk("t5_abort_clear", cnt_clear, 1);
    chk("t5_abort_done", done, 0);
    chk("t5_abort_busy", busy, 0);
    @(negedge clk);
    chk("t5_after_clear", cnt_clear, 0);
    chk("t5_after_done", done, 0);
`else
    service(2, 10, 12, 4);
    @(negedge clk);
    chk("t5_done_single", done, 0);
`endif

    // 6. reset in the middle of COUNT with req[3] held
    req_len = 16'h5000;
    req     = 4'b1000;
    wait_grant(n);
    chk("t6_grant_latency", n, 1);
    chk("t6_grant", grant, 4'b1000);
    repeat (3) @(negedge clk);
    chk("t6_counting", cnt_enable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_clear", cnt_clear, 1);
    chk("t6_rst_enable", cnt_enable, 0);
    chk("t6_rst_state", dbg_state_o, 0);
    rst = 1'b0;
    wait_grant(n);
    chk("t6_regrant_latency", n, 1);
    service(3, 5, 7, -1);
    req = 4'b0;
    @(negedge clk);
    chk("t6_done_single", done, 0);

    // 7. pointer after reset starts at 0
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    req_len = 16'h1111;
    req     = 4'b1010;
    wait_grant(n);
    chk("t7_grant_after_rst", grant, 4'b0010);
    service(1, 1, 3, -1);
    req = 4'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
